// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register, write-back select and
// retired-instruction counter for the RV32 core.
// Optional feature macro: LOAD_EXT_EN (sub-word load extraction in W stage).
// Only XLEN = 32 is supported.
module mem_wb_writeback #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             VALID_M,
  input  logic             RegWrite_M,
  input  logic [1:0]       ResultSrc_M,
  input  logic [2:0]       Funct3_M,
  input  logic [4:0]       Rd_M,
  input  logic [XLEN-1:0]  ALUResult_M,
  input  logic [XLEN-1:0]  ReadData_M,
  input  logic [XLEN-1:0]  PCPlus4_M,
  output logic [XLEN-1:0]  WD,
  output logic [4:0]       A3,
  output logic             RegWrite,
  output logic             VALID_W,
  output logic [CNT_W-1:0] RETIRED
);

  // W-stage entry
  logic             valid_w_reg,      valid_w_next;
  logic             regwrite_w_reg,   regwrite_w_next;
  logic [1:0]       result_src_w_reg, result_src_w_next;
  logic [2:0]       funct3_w_reg,     funct3_w_next;
  logic [4:0]       rd_w_reg,         rd_w_next;
  logic [XLEN-1:0]  alu_result_w_reg, alu_result_w_next;
  logic [XLEN-1:0]  read_data_w_reg,  read_data_w_next;
  logic [XLEN-1:0]  pc_plus4_w_reg,   pc_plus4_w_next;
  logic [CNT_W-1:0] retired_reg,      retired_next;

  logic [XLEN-1:0]  load_value;

  // Next-state: !EN holds everything, FLUSH bubbles (beats STALL), STALL holds, else capture.
  always_comb begin
    valid_w_next      = valid_w_reg;
    regwrite_w_next   = regwrite_w_reg;
    result_src_w_next = result_src_w_reg;
    funct3_w_next     = funct3_w_reg;
    rd_w_next         = rd_w_reg;
    alu_result_w_next = alu_result_w_reg;
    read_data_w_next  = read_data_w_reg;
    pc_plus4_w_next   = pc_plus4_w_reg;
    retired_next      = retired_reg;
    if (EN) begin
      if (FLUSH) begin
        // Data fields are left as they were; only the control bits matter for a bubble.
        valid_w_next    = 1'b0;
        regwrite_w_next = 1'b0;
      end else if (!STALL) begin
        valid_w_next      = VALID_M;
        regwrite_w_next   = RegWrite_M;
        result_src_w_next = ResultSrc_M;
        funct3_w_next     = Funct3_M;
        rd_w_next         = Rd_M;
        alu_result_w_next = ALUResult_M;
        read_data_w_next  = ReadData_M;
        pc_plus4_w_next   = PCPlus4_M;
        if (VALID_M) begin
          retired_next = retired_reg + 1'b1;
        end
      end
    end
  end

  // State register with synchronous reset taking priority over every other control.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_w_reg      <= 1'b0;
      regwrite_w_reg   <= 1'b0;
      result_src_w_reg <= 2'd0;
      funct3_w_reg     <= 3'd0;
      rd_w_reg         <= 5'd0;
      alu_result_w_reg <= '0;
      read_data_w_reg  <= '0;
      pc_plus4_w_reg   <= '0;
      retired_reg      <= '0;
    end else begin
      valid_w_reg      <= valid_w_next;
      regwrite_w_reg   <= regwrite_w_next;
      result_src_w_reg <= result_src_w_next;
      funct3_w_reg     <= funct3_w_next;
      rd_w_reg         <= rd_w_next;
      alu_result_w_reg <= alu_result_w_next;
      read_data_w_reg  <= read_data_w_next;
      pc_plus4_w_reg   <= pc_plus4_w_next;
      retired_reg      <= retired_next;
    end
  end

`ifdef LOAD_EXT_EN
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = read_data_w_reg[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = read_data_w_reg[16*gi +: 16];
    end
  endgenerate

  // Address low bits pick the lane; bit 0 is irrelevant for halfwords.
  assign sel_byte = byte_lane[alu_result_w_reg[1:0]];
  assign sel_half = half_lane[alu_result_w_reg[1]];

  // Sub-word extraction by load size/sign; unknown codes fall back to the full word.
  always_comb begin
    load_value = read_data_w_reg;
    case (funct3_w_reg)
      3'b000:  load_value = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      3'b100:  load_value = {{(XLEN-8){1'b0}}, sel_byte};
      3'b001:  load_value = {{(XLEN-16){sel_half[15]}}, sel_half};
      3'b101:  load_value = {{(XLEN-16){1'b0}}, sel_half};
      default: load_value = read_data_w_reg;
    endcase
  end
`else
  // Raw word is written back; the load-size field is carried but has no effect.
  logic unused_funct3;
  assign unused_funct3 = ^funct3_w_reg;
  assign load_value    = read_data_w_reg;
`endif

  // Write-back data select; code 3 is reserved and writes zero.
  always_comb begin
    WD = '0;
    case (result_src_w_reg)
      2'd0:    WD = alu_result_w_reg;
      2'd1:    WD = load_value;
      2'd2:    WD = pc_plus4_w_reg;
      default: WD = '0;
    endcase
  end

  // x0 is never written, and bubbles never write.
  assign RegWrite = valid_w_reg & regwrite_w_reg & (rd_w_reg != 5'd0);
  assign A3       = rd_w_reg;
  assign VALID_W  = valid_w_reg;
  assign RETIRED  = retired_reg;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed vector table, hand sequences (flush/stall/reset,
// counter wrap) and randomized traffic against a spec-level reference model.
module tb_mem_wb_writeback;

  localparam int CW = 8;

  logic          CLK;
  logic          RST, EN, STALL, FLUSH, VALID_M, RegWrite_M;
  logic [1:0]    ResultSrc_M;
  logic [2:0]    Funct3_M;
  logic [4:0]    Rd_M;
  logic [31:0]   ALUResult_M, ReadData_M, PCPlus4_M;
  logic [31:0]   WD;
  logic [4:0]    A3;
  logic          RegWrite, VALID_W;
  logic [CW-1:0] RETIRED;

  int checks   = 0;
  int failures = 0;

  mem_wb_writeback #(.XLEN(32), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .STALL(STALL), .FLUSH(FLUSH),
    .VALID_M(VALID_M), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
    .Funct3_M(Funct3_M), .Rd_M(Rd_M), .ALUResult_M(ALUResult_M),
    .ReadData_M(ReadData_M), .PCPlus4_M(PCPlus4_M),
    .WD(WD), .A3(A3), .RegWrite(RegWrite), .VALID_W(VALID_W), .RETIRED(RETIRED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef LOAD_EXT_EN
  localparam logic [31:0] EXP_LB  = 32'hFFFFFF80;
  localparam logic [31:0] EXP_LBU = 32'h00000080;
  localparam logic [31:0] EXP_LH  = 32'hFFFF80FF;
  localparam logic [31:0] EXP_LHU = 32'h000080FF;
`else
  localparam logic [31:0] EXP_LB  = 32'h80FF7F01;
  localparam logic [31:0] EXP_LBU = 32'h80FF7F01;
  localparam logic [31:0] EXP_LH  = 32'h80FF7F01;
  localparam logic [31:0] EXP_LHU = 32'h80FF7F01;
`endif

  typedef struct {
    logic        rst, en, stall, flush, valid, rw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc;
    logic        chk_data;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        regwrite, valid_w;
    logic [7:0]  ret;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, en, stall, flush, valid, rw,
                              input logic [1:0] src, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] alu, rdata, pc,
                              input logic chk, input logic [31:0] wd,
                              input logic [4:0] a3, input logic regw, vw,
                              input logic [7:0] ret);
    vec_t v;
    v.rst = rst; v.en = en; v.stall = stall; v.flush = flush; v.valid = valid; v.rw = rw;
    v.src = src; v.f3 = f3; v.rd = rd; v.alu = alu; v.rdata = rdata; v.pc = pc;
    v.chk_data = chk; v.wd = wd; v.a3 = a3; v.regwrite = regw; v.valid_w = vw; v.ret = ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, en, stall, flush, valid, rw,
                       input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, rdata, pc);
    RST = rst; EN = en; STALL = stall; FLUSH = flush; VALID_M = valid; RegWrite_M = rw;
    ResultSrc_M = src; Funct3_M = f3; Rd_M = rd;
    ALUResult_M = alu; ReadData_M = rdata; PCPlus4_M = pc;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input logic chk_data, input logic [31:0] wd,
                           input logic [4:0] a3, input logic regw, vw, input logic [7:0] ret);
    if (chk_data) begin
      check({tag, "_WD"}, WD, wd);
      check({tag, "_A3"}, {27'd0, A3}, {27'd0, a3});
    end
    check({tag, "_RegWrite"}, {31'd0, RegWrite}, {31'd0, regw});
    check({tag, "_VALID_W"}, {31'd0, VALID_W}, {31'd0, vw});
    check({tag, "_RETIRED"}, {24'd0, RETIRED}, {24'd0, ret});
    $display("%s: WD=%08h A3=%0d RegWrite=%0b VALID_W=%0b RETIRED=%0d", tag, WD, A3, RegWrite,
             VALID_W, RETIRED);
  endtask

  // Reference model: spec-level view of the W entry.
  logic        m_valid, m_rw, m_known;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdata, m_pc;
  int          m_ret;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] b, h;
`ifdef LOAD_EXT_EN
    b = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
    h = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
    if (f3 == 3'b000) return (b >= 32'd128) ? b - 32'd256 : b;
    if (f3 == 3'b100) return b;
    if (f3 == 3'b001) return (h >= 32'd32768) ? h - 32'd65536 : h;
    if (f3 == 3'b101) return h;
    return rdata;
`else
    b = 32'd0; h = 32'd0;
    return rdata + b + h;
`endif
  endfunction

  function automatic logic [31:0] ref_wd();
    if (m_src == 2'd0) return m_alu;
    if (m_src == 2'd1) return ref_load(m_f3, m_alu, m_rdata);
    if (m_src == 2'd2) return m_pc;
    return 32'd0;
  endfunction

  task automatic model_step(input logic rst, en, stall, flush, valid, rw,
                            input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] alu, rdata, pc);
    if (rst) begin
      m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
      m_alu = 0; m_rdata = 0; m_pc = 0; m_ret = 0; m_known = 1;
    end else if (!en) begin
      // frozen
    end else if (flush) begin
      m_valid = 0; m_rw = 0; m_known = 0;
    end else if (!stall) begin
      m_valid = valid; m_rw = rw; m_src = src; m_f3 = f3; m_rd = rd;
      m_alu = alu; m_rdata = rdata; m_pc = pc; m_known = 1;
      if (valid) m_ret = (m_ret + 1) % (1 << CW);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: one row per clock, expectations from the spec rules.
    vecs[0]  = mk(1,0,0,0,0,0, 0,0, 0, 0,0,0,               1, 0,0,0,0, 0);
    vecs[1]  = mk(1,0,0,0,0,0, 0,0, 0, 0,0,0,               1, 0,0,0,0, 0);
    vecs[2]  = mk(0,1,0,0,0,0, 0,0, 0, 0,0,0,               1, 0,0,0,0, 0);
    vecs[3]  = mk(0,1,0,0,1,1, 0,0, 5, 200,0,0,             1, 200,5,1,1, 1);
    vecs[4]  = mk(0,1,0,0,1,1, 0,0, 0, 200,0,0,             1, 200,0,0,1, 2);
    vecs[5]  = mk(0,1,0,0,1,1, 2,0, 1, 32'h55,0,32'h104,    1, 32'h104,1,1,1, 3);
    vecs[6]  = mk(0,1,1,0,1,1, 0,0, 7, 32'h999,0,0,         1, 32'h104,1,1,1, 3);
    vecs[7]  = mk(0,1,1,0,1,1, 0,0, 8, 32'h998,0,0,         1, 32'h104,1,1,1, 3);
    vecs[8]  = mk(0,1,1,0,1,1, 0,0, 9, 32'h997,0,0,         1, 32'h104,1,1,1, 3);
    vecs[9]  = mk(0,1,0,0,1,1, 0,0, 9, 32'h33,0,0,          1, 32'h33,9,1,1, 4);
    vecs[10] = mk(0,1,1,1,1,1, 0,0, 6, 32'h44,0,0,          0, 0,0,0,0, 4);
    vecs[11] = mk(0,1,0,0,1,1, 1,3'b000,10, 3,32'h80FF7F01,0, 1, EXP_LB,10,1,1, 5);
    vecs[12] = mk(0,1,0,0,1,1, 1,3'b100,10, 3,32'h80FF7F01,0, 1, EXP_LBU,10,1,1, 6);
    vecs[13] = mk(0,1,0,0,1,1, 1,3'b001,10, 2,32'h80FF7F01,0, 1, EXP_LH,10,1,1, 7);
    vecs[14] = mk(0,1,0,0,1,1, 1,3'b101,10, 2,32'h80FF7F01,0, 1, EXP_LHU,10,1,1, 8);
    vecs[15] = mk(0,1,0,0,1,1, 1,3'b010,10, 0,32'h80FF7F01,0, 1, 32'h80FF7F01,10,1,1, 9);
    vecs[16] = mk(0,1,0,0,1,1, 3,0, 11, 5,32'h1,32'h2,      1, 0,11,1,1, 10);
    vecs[17] = mk(0,1,0,0,0,1, 0,0, 12, 32'h77,0,0,         1, 32'h77,12,0,0, 10);
    vecs[18] = mk(0,0,0,0,1,1, 0,0, 13, 32'h88,0,0,         1, 32'h77,12,0,0, 10);
    vecs[19] = mk(0,0,1,1,1,1, 0,0, 13, 32'h88,0,0,         1, 32'h77,12,0,0, 10);
    vecs[20] = mk(0,1,0,0,1,1, 0,0, 13, 32'h1234,0,0,       1, 32'h1234,13,1,1, 11);
    vecs[21] = mk(1,1,1,0,1,1, 0,0, 14, 32'h5678,0,0,       1, 0,0,0,0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rw,
            vecs[i].src, vecs[i].f3, vecs[i].rd, vecs[i].alu, vecs[i].rdata, vecs[i].pc);
      tick();
      check_all($sformatf("row%0d", i), vecs[i].chk_data, vecs[i].wd, vecs[i].a3,
                vecs[i].regwrite, vecs[i].valid_w, vecs[i].ret);
    end

    // Hand sequence: flush alone, bubble held under stall, reset during stall+flush.
    drive(0,1,0,0,1,1, 0,0, 3, 32'hAA,0,0); tick();
    check_all("seq_capture", 1, 32'hAA, 3, 1, 1, 1);
    drive(0,1,0,1,1,1, 0,0, 4, 32'hBB,0,0); tick();
    check_all("seq_flush", 0, 0, 0, 0, 0, 1);
    drive(0,1,1,0,1,1, 0,0, 4, 32'hBB,0,0); tick();
    check_all("seq_stall_bubble", 0, 0, 0, 0, 0, 1);
    drive(1,1,1,1,1,1, 0,0, 4, 32'hBB,0,0); tick();
    check_all("seq_rst_in_flush", 1, 0, 0, 0, 0, 0);

    // Counter wrap: CW-bit counter returns to zero after 2^CW retirements.
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      drive(0,1,0,0,1,1, 0,0, 5'(i % 32), 32'(i),0,0); tick();
      check_all($sformatf("wrap%0d", i), 1, 32'(i), 5'(i % 32), ((i % 32) != 0), 1,
                8'((i + 1) % (1 << CW)));
    end

    // Randomized traffic against the reference model.
    model_step(1,0,0,0,0,0,0,0,0,0,0,0);
    drive(1,0,0,0,0,0,0,0,0,0,0,0); tick();
    check_all("rnd_init", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      logic r_rst, r_en, r_stall, r_flush, r_valid, r_rw;
      logic [1:0] r_src; logic [2:0] r_f3; logic [4:0] r_rd;
      logic [31:0] r_alu, r_rdata, r_pc;
      r_rst   = ($urandom_range(0, 255) == 0);
      r_en    = ($urandom_range(0, 7) != 0);
      r_stall = ($urandom_range(0, 5) == 0);
      r_flush = ($urandom_range(0, 7) == 0);
      r_valid = ($urandom_range(0, 3) != 0);
      r_rw    = ($urandom_range(0, 3) != 0);
      r_src   = 2'($urandom_range(0, 3));
      r_f3    = 3'($urandom_range(0, 7));
      r_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r_alu   = $urandom;
      r_rdata = $urandom;
      r_pc    = $urandom;
      drive(r_rst, r_en, r_stall, r_flush, r_valid, r_rw, r_src, r_f3, r_rd, r_alu, r_rdata, r_pc);
      model_step(r_rst, r_en, r_stall, r_flush, r_valid, r_rw, r_src, r_f3, r_rd, r_alu,
                 r_rdata, r_pc);
      tick();
      check_all($sformatf("rnd%0d", i), m_known, ref_wd(), m_rd,
                m_valid && m_rw && (m_rd != 5'd0), m_valid, 8'(m_ret));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
